seg_mux_driver: RTL
===================

# seg_mux_driver

Parametrised time-multiplexed driver for N-digit common-cathode/anode seven-segment displays with per-digit hex decode. It replaces the two-digit fixed-rate multiplexer. New behaviour: configurable digit count and dwell time, a dead-time blanking interval between digits that stops ghosting, a per-digit enable mask, and tear-free frame-synchronous loading of new display values. It sits between the top-level value sources (switches, adders, counters) and the board's segment and digit-power pins.

## Interface

Parameters:
- `NDIGITS`, default 2: number of digits driven; must be ≥ 1.
- `DWELL`, default 65536: cycles each digit is powered per slot; must be ≥ 1.
- `BLANK`, default 256: dead-time cycles before each digit's dwell, with all digits off; must be ≥ 1.

Ports:
- `clk`, input, 1: single system clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `load`, input, 1: one-cycle strobe that captures `digits_in` and `en_in` into the shadow registers.
- `digits_in`, input, 4*NDIGITS: hex value per digit; digit k is `[4k+3:4k]`.
- `en_in`, input, NDIGITS: per-digit enable; 0 keeps that digit dark during its slot.
- `power`, output, NDIGITS: digit power, active-high, one-hot or all-zero.
- `segs`, output, 7: segments {a,b,c,d,e,f,g}, active-low (0 = lit).
- `pending`, output, 1: shadow holds a load that has not yet been committed.
- `frame_tick`, output, 1: one-cycle pulse at each frame wrap.

## Operation

- **State:**
  - FSM states: BLANK and SHOW.
  - Digit index `idx` is a ceil(log2(NDIGITS))-bit counter, minimum 1 bit.
  - Slot timer is wide enough for max(DWELL, BLANK)−1.
  - Active registers and shadow registers each hold the digit values and the mask.
- **BLANK:**
  - `power` = 0 and `segs` = 7'h7F.
  - Stays in BLANK for BLANK cycles, then moves to SHOW.
- **SHOW:**
  - `power[idx]` = active mask bit `idx`; all other bits are 0.
  - `segs` = decode(active digit `idx`) when that mask bit is 1, otherwise 7'h7F.
  - Stays in SHOW for DWELL cycles, then moves to BLANK.
  - On leaving SHOW, `idx` increments and wraps from NDIGITS−1 to 0.
- **Decode table (active-low):**
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- **Load:**
  - When `load`=1, the shadow takes `digits_in`/`en_in` and `pending` goes to 1.
  - Successive loads before a commit overwrite the shadow; the last one wins.
- **Commit:**
  - Occurs on the edge where SHOW of digit NDIGITS−1 ends (the frame wrap).
  - If `pending`=1, active takes shadow and `pending` goes to 0.
  - `frame_tick` is 1 for the cycle following that edge, whether or not a commit happened.
- **Simultaneous load and wrap:** the commit copies the pre-load shadow. The new load is written to the shadow and `pending` stays 1, so it commits at the next wrap.
- **Reset (async assert):**
  - FSM = BLANK, `idx` = 0, timer = 0.
  - Active and shadow digits = 0; active and shadow masks = all 1s.
  - Outputs: `power` = 0, `segs` = 7'h7F, `pending` = 0, `frame_tick` = 0.
- **Reset mid-frame:** outputs go to their reset values immediately, with no wait for a clock edge.

## Timing

- All outputs are registered and change only on `clk` rising edges, except during asynchronous reset.
- Slot length is BLANK+DWELL cycles; frame length is NDIGITS*(BLANK+DWELL) cycles.
- Counting the first edge after `reset` deasserts as edge 1:
  - BLANK covers the cycles after edges 1..BLANK.
  - Digit 0 SHOW covers edges BLANK+1..BLANK+DWELL.
  - Later digits follow in the same pattern.
- `power` is never non-zero for two consecutive different digits. At least BLANK all-zero cycles separate any two different one-hot values.
- A load is visible on `segs` only from the first SHOW of digit 0 after the commit. Worst-case load-to-display latency is one frame plus BLANK+1 cycles.
- `pending` rises the cycle after a `load` strobe and falls the cycle after the commit edge.

## Test plan

Run with NDIGITS=4, DWELL=4, BLANK=2 (frame = 24 cycles).

1. **Reset and first frame:** release reset, no load. Expect `power` = 0000 for 2 cycles, then 0001 for 4 cycles with `segs`=0000001, then 2 blank cycles, then 0010 with `segs`=0000001. Expect `frame_tick` on cycle 25 only.
2. **Load and commit:** load `digits_in`=16'hF3A1, `en_in`=4'hF mid-frame. Expect `pending`=1 until the wrap, and no change in the current frame. In the next frame, expect `segs` = 1001111, 0001000, 0000110, 0111000 on digits 0–3.
3. **Mask:** load `en_in`=4'b0101. Expect `power` to go high only for digits 0 and 2. During the slots of digits 1 and 3, expect `power`=0000 and `segs`=7'h7F, with slot timing unchanged.
4. **Load on wrap edge:** strobe `load` (value 16'h1111) in the cycle of the wrap edge while a pending 16'h2222 exists. Expect the next frame to show 2s, `pending` to stay 1, and the frame after to show 1s.
5. **Reset mid-SHOW:** assert `reset` during digit 2 SHOW. Expect `power`=0, `segs`=7F and `pending`=0 immediately. After release, expect the sequence to restart at BLANK/digit 0 showing 0s.
6. **Dead-time property:** over 10 frames with random loads, assert `power` is one-hot or zero at all times. Assert every change between two different non-zero values passes through ≥2 zero cycles.

Source files
------------

// File: rtl/seg_mux_driver.sv
// seg_mux_driver
//
// Time-multiplexed driver for an N-digit seven-segment display with per-digit
// hex decode. Each digit slot is a blanking interval (all digits off) followed
// by a dwell interval in which one digit is powered. New values are written
// into a shadow copy and only become active at the frame wrap, so a frame is
// never drawn with a mix of old and new values.
//
// Parameters:
//   NDIGITS  number of digits driven (>= 1)
//   DWELL    cycles each digit is powered per slot (>= 1)
//   BLANK    dead-time cycles before each dwell, all digits off (>= 1)
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous reset, active low
//   load        one-cycle strobe capturing digits_in/en_in into the shadow
//   digits_in   hex value per digit, digit k at [4k+3:4k]
//   en_in       per-digit enable, 0 keeps that digit dark
//   power       digit power, active high, one-hot or zero
//   segs        segments {a,b,c,d,e,f,g}, active low
//   pending     shadow holds a load not yet committed
//   frame_tick  one-cycle pulse after each frame wrap

module seg_mux_driver #(
  parameter int NDIGITS = 2,
  parameter int DWELL   = 65536,
  parameter int BLANK   = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [4*NDIGITS-1:0] digits_in,
  input  logic [NDIGITS-1:0]   en_in,
  output logic [NDIGITS-1:0]   power,
  output logic [6:0]           segs,
  output logic                 pending,
  output logic                 frame_tick
);

  localparam int MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    wrap_q, wrap_d;

  logic [NDIGITS-1:0][3:0] active_dig_q, active_dig_d;
  logic [NDIGITS-1:0]      active_en_q, active_en_d;
  logic [NDIGITS-1:0][3:0] shadow_dig_q, shadow_dig_d;
  logic [NDIGITS-1:0]      shadow_en_q, shadow_en_d;
  logic                    pending_q, pending_d;

  logic [NDIGITS-1:0]      power_q, power_d;
  logic [6:0]              segs_q, segs_d;
  logic                    frame_tick_q, frame_tick_d;

  function automatic logic [6:0] hex_to_segs(input logic [3:0] v);
    hex_to_segs = 7'h7F;
    case (v)
      4'h0: hex_to_segs = 7'b0000001;
      4'h1: hex_to_segs = 7'b1001111;
      4'h2: hex_to_segs = 7'b0010010;
      4'h3: hex_to_segs = 7'b0000110;
      4'h4: hex_to_segs = 7'b1001100;
      4'h5: hex_to_segs = 7'b0100100;
      4'h6: hex_to_segs = 7'b0100000;
      4'h7: hex_to_segs = 7'b0001111;
      4'h8: hex_to_segs = 7'b0000000;
      4'h9: hex_to_segs = 7'b0000100;
      4'hA: hex_to_segs = 7'b0001000;
      4'hB: hex_to_segs = 7'b1100000;
      4'hC: hex_to_segs = 7'b0110001;
      4'hD: hex_to_segs = 7'b1000010;
      4'hE: hex_to_segs = 7'b0110000;
      4'hF: hex_to_segs = 7'b0111000;
      default: hex_to_segs = 7'h7F;
    endcase
  endfunction

  // The sequencer runs one cycle ahead of the pins: outputs are a registered
  // copy of what the current state implies. This makes the reset state count
  // as a blank cycle-zero so the first edge after release starts the BLANK
  // interval seen on the pins. wrap_d flags the state-side end of the last
  // digit's SHOW; the commit happens one edge later, in step with the pins.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    idx_d   = idx_q;
    wrap_d  = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (timer_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          timer_d = '0;
        end
      end
      ST_SHOW: begin
        if (timer_q == DWELL_LAST) begin
          state_d = ST_BLANK;
          timer_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        timer_d = '0;
      end
    endcase
  end

  // Pin values implied by the current state; a masked digit keeps its slot
  // timing but stays dark.
  always_comb begin
    power_d = '0;
    segs_d  = 7'h7F;
    if (state_q == ST_SHOW && active_en_q[idx_q]) begin
      power_d[idx_q] = 1'b1;
      segs_d         = hex_to_segs(active_dig_q[idx_q]);
    end
  end

  // Shadow/active handling. The commit reads the shadow before this cycle's
  // load lands in it, so a load coinciding with the wrap stays pending for
  // the following frame.
  always_comb begin
    active_dig_d = active_dig_q;
    active_en_d  = active_en_q;
    shadow_dig_d = shadow_dig_q;
    shadow_en_d  = shadow_en_q;
    pending_d    = pending_q;
    frame_tick_d = wrap_q;
    if (wrap_q && pending_q) begin
      active_dig_d = shadow_dig_q;
      active_en_d  = shadow_en_q;
      pending_d    = 1'b0;
    end
    if (load) begin
      shadow_dig_d = digits_in;
      shadow_en_d  = en_in;
      pending_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_BLANK;
      timer_q      <= '0;
      idx_q        <= '0;
      wrap_q       <= 1'b0;
      active_dig_q <= '0;
      active_en_q  <= '1;
      shadow_dig_q <= '0;
      shadow_en_q  <= '1;
      pending_q    <= 1'b0;
      power_q      <= '0;
      segs_q       <= 7'h7F;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      wrap_q       <= wrap_d;
      active_dig_q <= active_dig_d;
      active_en_q  <= active_en_d;
      shadow_dig_q <= shadow_dig_d;
      shadow_en_q  <= shadow_en_d;
      pending_q    <= pending_d;
      power_q      <= power_d;
      segs_q       <= segs_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign power      = power_q;
  assign segs       = segs_q;
  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;

endmodule
